// File: rtl/semisumador.sv
// Registered lane-wise half adder: per lane sum = a ^ b, carry = a & b, with a valid strobe.
// Optional saturating carry-event counter enabled by defining SEMISUMADOR_CNT_EN.
module semisumador #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef SEMISUMADOR_CNT_EN
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] carry_cnt,
`endif
  output logic [WIDTH-1:0] sum,
  output logic [WIDTH-1:0] carry,
  output logic             out_valid
);

  logic [WIDTH-1:0] sum_next;
  logic [WIDTH-1:0] carry_next;
  logic [WIDTH-1:0] sum_reg;
  logic [WIDTH-1:0] carry_reg;
  logic             out_valid_reg;

  // Lanes are independent; no carry crosses between them.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_lane
    assign sum_next[gi]   = a[gi] ^ b[gi];
    assign carry_next[gi] = a[gi] & b[gi];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_reg       <= '0;
      carry_reg     <= '0;
      out_valid_reg <= 1'b0;
    end else begin
      out_valid_reg <= in_valid;
      if (in_valid) begin
        sum_reg   <= sum_next;
        carry_reg <= carry_next;
      end
    end
  end

  assign sum       = sum_reg;
  assign carry     = carry_reg;
  assign out_valid = out_valid_reg;

`ifdef SEMISUMADOR_CNT_EN
  localparam int PC_W  = $clog2(WIDTH + 1);
  localparam int SUM_W = ((CNT_W > PC_W) ? CNT_W : PC_W) + 1;

  logic [PC_W-1:0]  carry_pop;
  logic [SUM_W-1:0] cnt_sum;
  logic [CNT_W-1:0] carry_cnt_reg;
  logic [CNT_W-1:0] carry_cnt_next;

  always_comb begin
    carry_pop = '0;
    for (int i = 0; i < WIDTH; i++) begin
      carry_pop = carry_pop + PC_W'(carry_next[i]);
    end
  end

  // Sum is one bit wider than either operand so overflow is detectable before clamping.
  assign cnt_sum = SUM_W'(carry_cnt_reg) + SUM_W'(carry_pop);

  always_comb begin
    carry_cnt_next = carry_cnt_reg;
    if (cnt_clr) begin
      carry_cnt_next = '0;
    end else if (in_valid) begin
      if (cnt_sum > SUM_W'({CNT_W{1'b1}})) begin
        carry_cnt_next = {CNT_W{1'b1}};
      end else begin
        carry_cnt_next = cnt_sum[CNT_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      carry_cnt_reg <= '0;
    end else begin
      carry_cnt_reg <= carry_cnt_next;
    end
  end

  assign carry_cnt = carry_cnt_reg;
`endif

endmodule

// File: tb/tb_semisumador.sv
// Directed self-checking bench for semisumador (WIDTH=4); counter checks run when SEMISUMADOR_CNT_EN is defined.
module tb_semisumador;

  localparam int WIDTH = 4;
  localparam int CNT_W = 2;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] carry;
  logic             out_valid;
`ifdef SEMISUMADOR_CNT_EN
  logic             cnt_clr;
  logic [CNT_W-1:0] carry_cnt;
`endif

  int checks;
  int errors;

  semisumador #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
`ifdef SEMISUMADOR_CNT_EN
    .cnt_clr   (cnt_clr),
    .carry_cnt (carry_cnt),
`endif
    .sum       (sum),
    .carry     (carry),
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b1; a = 4'hF; b = 4'hF;
    #1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({sum, carry, out_valid} !== 9'b0) begin
        errors++;
        $display("FAIL reset[%0d] sum=%b carry=%b out_valid=%b required 0000/0000/0", i, sum, carry, out_valid);
      end
      $display("reset cycle %0d sum=%b carry=%b out_valid=%b", i, sum, carry, out_valid);
    end
`ifdef SEMISUMADOR_CNT_EN
    checks++;
    if (carry_cnt !== 2'd0) begin
      errors++;
      $display("FAIL reset_cnt carry_cnt=%0d required 0", carry_cnt);
    end
`endif
    in_valid = 1'b0;
    #2 rst_n = 1'b1;
    tick();
  endtask

  task automatic test_exhaustive();
    logic [1:0] ab_vec [4];
    logic [1:0] exp_vec [4];
    ab_vec  = '{2'b00, 2'b01, 2'b10, 2'b11};
    exp_vec = '{2'b00, 2'b01, 2'b01, 2'b10}; // {carry, sum}
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      a = {3'b000, ab_vec[i][1]};
      b = {3'b000, ab_vec[i][0]};
      tick();
      checks++;
      if ({carry[0], sum[0], out_valid} !== {exp_vec[i], 1'b1} || sum[3:1] !== 3'b0 || carry[3:1] !== 3'b0) begin
        errors++;
        $display("FAIL exhaustive ab=%b carry,sum,valid=%b%b%b required %b1 (upper lanes sum=%b carry=%b)",
                 ab_vec[i], carry[0], sum[0], out_valid, exp_vec[i], sum[3:1], carry[3:1]);
      end
      $display("exhaustive ab=%b -> carry=%b sum=%b out_valid=%b", ab_vec[i], carry[0], sum[0], out_valid);
    end
  endtask

  task automatic test_hold();
    in_valid = 1'b1; a = 4'hF; b = 4'hF;
    tick();
    in_valid = 1'b0; a = 4'h0; b = 4'h5;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (sum !== 4'h0 || carry !== 4'hF || out_valid !== 1'b0) begin
        errors++;
        $display("FAIL hold[%0d] sum=%b carry=%b out_valid=%b required 0000/1111/0", i, sum, carry, out_valid);
      end
      $display("hold cycle %0d sum=%b carry=%b out_valid=%b", i, sum, carry, out_valid);
    end
  endtask

  task automatic test_multilane();
    in_valid = 1'b1; a = 4'b1100; b = 4'b1010;
    tick();
    in_valid = 1'b0;
    checks++;
    if (sum !== 4'b0110 || carry !== 4'b1000 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL multilane sum=%b carry=%b out_valid=%b required 0110/1000/1", sum, carry, out_valid);
    end
    $display("multilane a=1100 b=1010 -> sum=%b carry=%b", sum, carry);
  endtask

  task automatic test_back_to_back();
    logic [3:0] av [3];
    logic [3:0] bv [3];
    av = '{4'b0101, 4'b1111, 4'b0011};
    bv = '{4'b0110, 4'b0001, 4'b1011};
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; a = av[i]; b = bv[i];
      tick();
      checks++;
      if (sum !== (av[i] ^ bv[i]) || carry !== (av[i] & bv[i]) || out_valid !== 1'b1) begin
        errors++;
        $display("FAIL back_to_back[%0d] sum=%b carry=%b out_valid=%b required %b/%b/1",
                 i, sum, carry, out_valid, av[i] ^ bv[i], av[i] & bv[i]);
      end
      $display("back_to_back a=%b b=%b -> sum=%b carry=%b", av[i], bv[i], sum, carry);
    end
    in_valid = 1'b0;
  endtask

  task automatic test_async_reset();
    in_valid = 1'b1; a = 4'b1110; b = 4'b0111;
    tick();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({sum, carry, out_valid} !== 9'b0) begin
      errors++;
      $display("FAIL async_reset sum=%b carry=%b out_valid=%b required 0000/0000/0", sum, carry, out_valid);
    end
    $display("async_reset mid-cycle sum=%b carry=%b out_valid=%b", sum, carry, out_valid);
    in_valid = 1'b0;
    #2 rst_n = 1'b1;
    tick();
    checks++;
    if ({sum, carry, out_valid} !== 9'b0) begin
      errors++;
      $display("FAIL post_reset_idle sum=%b carry=%b out_valid=%b required 0000/0000/0", sum, carry, out_valid);
    end
    in_valid = 1'b1; a = 4'b1001; b = 4'b1000;
    tick();
    in_valid = 1'b0;
    checks++;
    if (sum !== 4'b0001 || carry !== 4'b1000 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL first_capture sum=%b carry=%b out_valid=%b required 0001/1000/1", sum, carry, out_valid);
    end
    $display("first capture after reset sum=%b carry=%b", sum, carry);
  endtask

`ifdef SEMISUMADOR_CNT_EN
  task automatic test_counter();
    logic [CNT_W-1:0] exp_cnt [3];
    exp_cnt = '{2'd2, 2'd3, 2'd3};
    rst_n = 1'b0; in_valid = 1'b0; cnt_clr = 1'b0;
    #2 rst_n = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; a = 4'b0011; b = 4'b0011;
      tick();
      checks++;
      if (carry_cnt !== exp_cnt[i]) begin
        errors++;
        $display("FAIL counter_sat[%0d] carry_cnt=%0d required %0d", i, carry_cnt, exp_cnt[i]);
      end
      $display("counter capture %0d carry_cnt=%0d", i, carry_cnt);
    end
    cnt_clr = 1'b1;
    tick();
    checks++;
    if (carry_cnt !== 2'd0) begin
      errors++;
      $display("FAIL counter_clr carry_cnt=%0d required 0", carry_cnt);
    end
    cnt_clr = 1'b0; a = 4'b0001; b = 4'b1001;
    tick();
    in_valid = 1'b0;
    checks++;
    if (carry_cnt !== 2'd1) begin
      errors++;
      $display("FAIL counter_inc carry_cnt=%0d required 1", carry_cnt);
    end
    $display("counter after clear and one carry carry_cnt=%0d", carry_cnt);
  endtask
`endif

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0;
`ifdef SEMISUMADOR_CNT_EN
    cnt_clr = 1'b0;
`endif
    test_reset();
    test_exhaustive();
    test_hold();
    test_multilane();
    test_back_to_back();
    test_async_reset();
`ifdef SEMISUMADOR_CNT_EN
    test_counter();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
